// File: rtl/matrix_c_writer.sv
// rtl/matrix_c_writer.sv - accumulates multiplier products into matrix C elements and writes them row-major
// Optional feature: define MATRIX_C_SATURATE_EN for saturating accumulation with a sticky ovf flag.
module matrix_c_writer #(
    parameter int MATRIX_C_ROWS      = 8,
    parameter int MATRIX_C_COLUMNS   = 8,
    parameter int DOT_LENGTH         = 8,
    parameter int MATRIX_C_MEM_DEPTH = 64,
    parameter int MATRIX_MEM_WIDTH   = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [MATRIX_MEM_WIDTH-1:0]           mult_out,
    input  logic                                  mult_done,
    output logic                                  wr_en,
    output logic [$clog2(MATRIX_C_MEM_DEPTH)-1:0] wr_address,
    output logic [MATRIX_MEM_WIDTH-1:0]           wr_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  ovf
);
    localparam int W  = MATRIX_MEM_WIDTH;
    localparam int AW = $clog2(MATRIX_C_MEM_DEPTH);
    localparam int TW = $clog2(DOT_LENGTH);
    localparam int RW = (MATRIX_C_ROWS > 1) ? $clog2(MATRIX_C_ROWS) : 1;
    localparam int CW = (MATRIX_C_COLUMNS > 1) ? $clog2(MATRIX_C_COLUMNS) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, FINISH} state_t;

    state_t              state;
    logic signed [W-1:0] acc;
    logic [TW-1:0]       term_cnt;
    logic [RW-1:0]       row_cnt;
    logic [CW-1:0]       col_cnt;
    logic [AW-1:0]       row_offset;
    logic                last_elem;
    logic [W-1:0]        sum;
    logic                add_ovf;
    logic                at_last_col;
    logic                at_last_elem;

`ifdef MATRIX_C_SATURATE_EN
    logic [W:0] sum_ext;
    // One guard bit exposes signed overflow: it differs from the result sign bit.
    always_comb begin
        sum_ext = {acc[W-1], acc} + {mult_out[W-1], mult_out};
        add_ovf = sum_ext[W] ^ sum_ext[W-1];
        if (add_ovf)
            sum = sum_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            sum = sum_ext[W-1:0];
    end
`else
    always_comb begin
        sum     = acc + mult_out;
        add_ovf = 1'b0;
    end
`endif

    assign at_last_col  = (col_cnt == CW'(MATRIX_C_COLUMNS - 1));
    assign at_last_elem = at_last_col && (row_cnt == RW'(MATRIX_C_ROWS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            term_cnt   <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            row_offset <= '0;
            last_elem  <= 1'b0;
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        acc        <= '0;
                        term_cnt   <= '0;
                        row_cnt    <= '0;
                        col_cnt    <= '0;
                        row_offset <= '0;
                        ovf        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (mult_done) begin
                        ovf <= ovf | add_ovf;
                        if (term_cnt == TW'(DOT_LENGTH - 1)) begin
                            wr_data    <= sum;
                            wr_address <= row_offset + AW'(col_cnt);
                            wr_en      <= 1'b1;
                            last_elem  <= at_last_elem;
                            acc        <= '0;
                            term_cnt   <= '0;
                            // Counters move to the next element now so WRITE can accept its first term.
                            if (at_last_col) begin
                                col_cnt    <= '0;
                                row_cnt    <= row_cnt + 1'b1;
                                row_offset <= row_offset + AW'(MATRIX_C_COLUMNS);
                            end else begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                            state <= WRITE;
                        end else begin
                            acc      <= sum;
                            term_cnt <= term_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    if (last_elem) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        if (mult_done) begin
                            acc      <= mult_out;
                            term_cnt <= TW'(1);
                        end
                        state <= ACCUM;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_c_writer.sv
// tb/tb_matrix_c_writer.sv - directed self-checking bench for matrix_c_writer (2x2 result, dot length 2)
module tb_matrix_c_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] mult_out;
    logic        mult_done;
    logic        wr_en;
    logic [5:0]  wr_address;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        ovf;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [5:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          done_q[$];

    matrix_c_writer #(
        .MATRIX_C_ROWS(2), .MATRIX_C_COLUMNS(2), .DOT_LENGTH(2),
        .MATRIX_C_MEM_DEPTH(64), .MATRIX_MEM_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mult_out(mult_out),
        .mult_done(mult_done), .wr_en(wr_en), .wr_address(wr_address),
        .wr_data(wr_data), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_address);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (done) done_q.push_back(cyc);
    end

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); done_q.delete();
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1; mult_done = 1'b0;
    endtask

    task automatic prod(input logic [31:0] v, output int c);
        @(negedge clk); start = 1'b0; mult_done = 1'b1; mult_out = v; c = cyc;
    endtask

    task automatic gap(input int n);
        repeat (n) begin @(negedge clk); start = 1'b0; mult_done = 1'b0; end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); start = 1'b0; mult_done = 1'b0;
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_pass(input logic [31:0] v[8], input int gap_n, input bit extra,
                            output int c2[4], output bit b1, output bit ok);
        int c;
        do_start();
        for (int i = 0; i < 8; i++) begin
            prod(v[i], c);
            if (i == 0) b1 = busy;
            if (i % 2 == 1) c2[i/2] = c;
            if (gap_n > 0) gap(gap_n);
        end
        if (extra) prod(32'd999, c);
        wait_idle(ok);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mult_done = 1'b1; mult_out = 32'h55;
        repeat (2) @(negedge clk);
        compared++; if (wr_en !== 1'b0) begin mismatched++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got=%b exp=0", done); end
        compared++; if (ovf !== 1'b0) begin mismatched++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        compared++; if (wr_address !== 6'd0) begin mismatched++; $display("FAIL reset_addr got=%0d exp=0", wr_address); end
        compared++; if (wr_data !== 32'd0) begin mismatched++; $display("FAIL reset_data got=%h exp=0", wr_data); end
        rst_n = 1'b1; mult_done = 1'b0;
        // mult_done in IDLE must not produce anything
        mult_done = 1'b1; gap(0); @(negedge clk); @(negedge clk); mult_done = 1'b0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic check_pass(input string name, input logic [31:0] exp[4], input int c2[4]);
        compared++;
        if (wa_q.size() != 4) begin mismatched++; $display("FAIL %s_writes got=%0d exp=4", name, wa_q.size()); end
        for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
            compared++;
            if (wa_q[k] !== 6'(k)) begin mismatched++; $display("FAIL %s_addr%0d got=%0d exp=%0d", name, k, wa_q[k], k); end
            compared++;
            if (wd_q[k] !== exp[k]) begin mismatched++; $display("FAIL %s_data%0d got=%h exp=%h", name, k, wd_q[k], exp[k]); end
            compared++;
            if (wc_q[k] != c2[k] + 1) begin mismatched++; $display("FAIL %s_lat%0d got=%0d exp=%0d", name, k, wc_q[k], c2[k] + 1); end
        end
        compared++;
        if (done_q.size() != 1) begin mismatched++; $display("FAIL %s_done_cnt got=%0d exp=1", name, done_q.size()); end
        else if (wc_q.size() == 4) begin
            compared++;
            if (done_q[0] != wc_q[3] + 1) begin mismatched++; $display("FAIL %s_done_cyc got=%0d exp=%0d", name, done_q[0], wc_q[3] + 1); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] v[8];
        logic [31:0] e[4];
        int c2[4]; bit b1, ok;
        v = '{1, 2, 3, 4, 5, 6, 7, 8};
        e = '{3, 7, 11, 15};
        clear_log();
        run_pass(v, 0, 1'b0, c2, b1, ok);
        compared++; if (b1 !== 1'b1) begin mismatched++; $display("FAIL basic_busy got=%b exp=1", b1); end
        compared++; if (!ok) begin mismatched++; $display("FAIL basic_idle got=busy exp=idle"); end
        check_pass("basic", e, c2);
    endtask

    task automatic test_gaps();
        logic [31:0] v[8];
        logic [31:0] e[4];
        int c2[4]; bit b1, ok;
        v = '{1, 2, 3, 4, 5, 6, 7, 8};
        e = '{3, 7, 11, 15};
        clear_log();
        run_pass(v, 3, 1'b0, c2, b1, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL gaps_idle got=busy exp=idle"); end
        check_pass("gaps", e, c2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v[8];
        logic [31:0] e[4];
        int c2[4]; bit b1, ok;
        v = '{32'hFFFFFFFB, 3, 100, 32'hFFFFFFFF, 32'h12340000, 32'h00005678, 32'hFFFFFFFF, 32'hFFFFFFFF};
        e = '{32'hFFFFFFFE, 99, 32'h12345678, 32'hFFFFFFFE};
        clear_log();
        // extra product lands on the last WRITE cycle and must be dropped
        run_pass(v, 0, 1'b1, c2, b1, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL b2b_idle got=busy exp=idle"); end
        check_pass("b2b", e, c2);
    endtask

    task automatic test_overflow();
        logic [31:0] v[8];
        int c2[4]; bit b1, ok;
        logic [31:0] exp_d;
        logic        exp_o;
`ifdef MATRIX_C_SATURATE_EN
        exp_d = 32'h7FFFFFFF; exp_o = 1'b1;
`else
        exp_d = 32'h80000000; exp_o = 1'b0;
`endif
        v = '{32'h7FFFFFFF, 1, 0, 0, 0, 0, 0, 0};
        clear_log();
        run_pass(v, 0, 1'b0, c2, b1, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL ovf_idle got=busy exp=idle"); end
        compared++;
        if (wd_q.size() < 1 || wd_q[0] !== exp_d) begin
            mismatched++; $display("FAIL ovf_data got=%h exp=%h", (wd_q.size() > 0) ? wd_q[0] : 32'hx, exp_d);
        end
        compared++; if (ovf !== exp_o) begin mismatched++; $display("FAIL ovf_flag got=%b exp=%b", ovf, exp_o); end
        do_start();
        @(negedge clk); start = 1'b0;
        compared++; if (ovf !== 1'b0) begin mismatched++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
        v = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin int c; prod(v[i], c); end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        int c; bit ok;
        clear_log();
        do_start();
        prod(1, c); prod(2, c); prod(3, c); prod(4, c);
        @(negedge clk); rst_n = 1'b0; mult_done = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        compared++; if (wr_en !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_out got=wr_en%b busy%b exp=00", wr_en, busy); end
        compared++; if (wr_address !== 6'd0 || wr_data !== 32'd0) begin mismatched++; $display("FAIL rst_mid_clr got=%0d/%h exp=0/0", wr_address, wr_data); end
        for (int i = 0; i < 6; i++) prod(32'(i + 20), c);
        gap(4);
        compared++; if (wa_q.size() != 2) begin mismatched++; $display("FAIL rst_mid_writes got=%0d exp=2", wa_q.size()); end
        compared++; if (done_q.size() != 0) begin mismatched++; $display("FAIL rst_mid_done got=%0d exp=0", done_q.size()); end
        clear_log();
        do_start();
        prod(9, c); prod(10, c);
        gap(2);
        compared++;
        if (wa_q.size() < 1 || wa_q[0] !== 6'd0 || wd_q[0] !== 32'd19) begin
            mismatched++; $display("FAIL rst_restart got=%0d writes exp=addr0 data 19", wa_q.size());
        end
        for (int i = 0; i < 6; i++) prod(1, c);
        wait_idle(ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL rst_restart_idle got=busy exp=idle"); end
    endtask

    task automatic test_start_busy();
        logic [31:0] e[4];
        int c2[4]; int c; bit ok;
        e = '{3, 7, 11, 15};
        clear_log();
        do_start();
        prod(1, c); prod(2, c); c2[0] = c;
        prod(3, c); start = 1'b1;
        prod(4, c); c2[1] = c; start = 1'b1;
        prod(5, c); prod(6, c); c2[2] = c;
        prod(7, c); prod(8, c); c2[3] = c;
        wait_idle(ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL sb_idle got=busy exp=idle"); end
        check_pass("start_busy", e, c2);
    endtask

    initial begin
        start = 1'b0; mult_done = 1'b0; mult_out = '0; rst_n = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_start_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/matrix_c_writer.md
MATRIX_C_WRITER -- requirements
Module: matrix_c_writer

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- MATRIX_C_ROWS, 8, result rows.
- MATRIX_C_COLUMNS, 8, result columns.
- DOT_LENGTH, 8, products summed per result element; legal values are >=2.
- MATRIX_C_MEM_DEPTH, 64, result memory words; legal values are >=ROWS*COLUMNS.
- MATRIX_MEM_WIDTH, 32, data width.

REQ-002 Reset rst_n SHALL be synchronous and active-low; the clock SHALL be clk.

REQ-003 Ports SHALL be (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- start, in, 1, begin one full matrix pass.
- mult_out, in, MATRIX_MEM_WIDTH, signed product from the multiplier.
- mult_done, in, 1, mult_out valid this cycle.
- wr_en, out, 1, result memory write strobe.
- wr_address, out, $clog2(MATRIX_C_MEM_DEPTH), result address.
- wr_data, out, MATRIX_MEM_WIDTH, result element.
- busy, out, 1, pass in progress.
- done, out, 1, one-cycle pulse at pass completion.
- ovf, out, 1, sticky saturation flag.

Function
REQ-004 All outputs SHALL be registered.

REQ-005 The FSM SHALL have four states: IDLE, ACCUM, WRITE, FINISH.

REQ-006 In IDLE, start=1 SHALL clear acc, term_cnt, row_cnt, col_cnt, row_offset and ovf, and go to ACCUM; mult_done in IDLE SHALL be ignored.

REQ-007 In ACCUM, each cycle with mult_done=1 SHALL add mult_out to acc and increment term_cnt; cycles with mult_done=0 SHALL hold all state.

REQ-008 In ACCUM, mult_done=1 with term_cnt==DOT_LENGTH-1 SHALL move the FSM to WRITE.

REQ-009 On that cycle, wr_data SHALL be loaded with the final sum (acc+mult_out) and wr_address with row_offset+col_cnt.

REQ-010 In WRITE, wr_en SHALL be 1 for exactly one cycle, one cycle after the final mult_done; the write latency is therefore 1 cycle.

REQ-011 row_offset SHALL advance by MATRIX_C_COLUMNS per row; no multiplier is permitted.

REQ-012 Write order SHALL be row-major: col_cnt increments; on col_cnt==MATRIX_C_COLUMNS-1 it wraps to 0, and row_cnt and row_offset advance.

REQ-013 A mult_done=1 arriving during WRITE SHALL start the next element with no bubble: acc<=mult_out, term_cnt<=1.

REQ-014 Leaving WRITE SHALL go to FINISH if the written element was (ROWS-1, COLUMNS-1), else to ACCUM.

REQ-015 A mult_done arriving during WRITE of the last element SHALL be discarded.

REQ-016 FINISH SHALL assert done=1 for one cycle and then go to IDLE.

REQ-017 busy SHALL be 1 in ACCUM, WRITE and FINISH, and 0 in IDLE.

REQ-018 start while busy=1 SHALL be ignored.

REQ-019 acc SHALL be MATRIX_MEM_WIDTH bits, signed two's complement.

REQ-020 wr_en SHALL be 0 in every state except WRITE.

Reset
REQ-021 rst_n=0 SHALL force state=IDLE and clear every counter, acc, wr_en, wr_address, wr_data, busy, done and ovf on the next clk edge.

REQ-022 Reset asserted mid-pass SHALL abort the pass with no further write and no done pulse.

REQ-023 After a mid-pass reset, a new start SHALL restart at address 0.

Configuration
REQ-024 The macro MATRIX_C_SATURATE_EN SHALL select the accumulation overflow behaviour.

REQ-025 With MATRIX_C_SATURATE_EN defined, additions that overflow SHALL clamp to 2^(W-1)-1 or -2^(W-1) and set ovf, which stays set until the next start or reset.

REQ-026 Without MATRIX_C_SATURATE_EN, additions SHALL wrap modulo 2^W and ovf SHALL be constant 0.

Verification
Scenarios REQ-027 to REQ-031 use ROWS=COLUMNS=DOT_LENGTH=2, W=32.

REQ-027 Basic pass: start, then mult_done with values 1,2 | 3,4 | 5,6 | 7,8 on consecutive cycles -> writes (0,3), (1,7), (2,11), (3,15), then done 1 cycle after the last write, and busy returns to 0.

REQ-028 Gaps: mult_done deasserted 3 cycles between every product -> same addresses and data as REQ-027; wr_en asserted exactly 1 cycle after each second product.

REQ-029 Back-to-back: a product on the WRITE cycle -> no bubble, and the element counts it as its first term.

REQ-030 Overflow, element 0 fed 0x7FFFFFFF,0x00000001:
- with MATRIX_C_SATURATE_EN -> wr_data=0x7FFFFFFF, ovf=1;
- without it -> wr_data=0x80000000, ovf=0.

REQ-031 Reset and start handling:
- rst_n pulsed low after the second write -> no further wr_en, no done;
- a subsequent start restarts at address 0;
- start during busy has no effect.
